// File: rtl/aes_key_expand_if.sv
// Key-load / round-key handshake bundle for the AES-128 key-schedule engine.
// The slave modport is the engine side; the master modport is the key loader plus round-key consumer.
interface aes_key_expand_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    modport slave (
        input  key_in,
        input  key_valid,
        output key_ready,
        output rk_out,
        output rk_round,
        output rk_valid,
        input  rk_ready,
        output busy,
        output done
    );

    modport master (
        output key_in,
        output key_valid,
        input  key_ready,
        input  rk_out,
        input  rk_round,
        input  rk_valid,
        output rk_ready,
        input  busy,
        input  done
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts one cipher key and emits round keys 0..10 over a valid/ready handshake.
// Optional macro KEYEXP_SBOX_PIPE_EN registers the SubWord result, adding one cycle per round.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_expand_if.slave  io_kx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_CALC = 2'b10
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Entry 0 sits in the most significant byte, so entry b starts at bit 8*(255-b) = {~b, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_key_ready;
    logic           w_key_ready_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_rk_valid;
    logic           w_rk_valid_nxt;
    logic [127:0]   r_rk_out;
    logic [127:0]   w_rk_out_nxt;
    logic [3:0]     r_rk_round;
    logic [3:0]     w_rk_round_nxt;
    logic [7:0]     r_rcon;
    logic [7:0]     w_rcon_nxt;

    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [31:0]    w_t;
    logic [31:0]    w_w0;
    logic [31:0]    w_w1;
    logic [31:0]    w_w2;
    logic [31:0]    w_w3;
    logic [127:0]   w_round_key;
    logic [7:0]     w_rcon_xt;

    // RotWord of w3 followed by four S-box lookups.
    assign w_rot = {r_rk_out[23:0], r_rk_out[31:24]};
    assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};

`ifdef KEYEXP_SBOX_PIPE_EN
    logic [31:0]    r_sub;
    logic [31:0]    w_sub_nxt;
    assign w_t = r_sub ^ {r_rcon, 24'h000000};
`else
    assign w_t = w_sub ^ {r_rcon, 24'h000000};
`endif

    assign w_w0        = r_rk_out[127:96] ^ w_t;
    assign w_w1        = r_rk_out[95:64]  ^ w_w0;
    assign w_w2        = r_rk_out[63:32]  ^ w_w1;
    assign w_w3        = r_rk_out[31:0]   ^ w_w2;
    assign w_round_key = {w_w0, w_w1, w_w2, w_w3};
    assign w_rcon_xt   = xtime(r_rcon);

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_rk_out_nxt   = r_rk_out;
        w_rk_round_nxt = r_rk_round;
        w_rk_valid_nxt = r_rk_valid;
        w_rcon_nxt     = r_rcon;
        w_done_nxt     = 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
        w_sub_nxt      = r_sub;
`endif
        case (r_state)
            ST_IDLE: begin
                if (io_kx.key_valid && r_key_ready) begin
                    w_state_nxt    = ST_EMIT;
                    w_rk_out_nxt   = io_kx.key_in;
                    w_rk_round_nxt = 4'd0;
                    w_rk_valid_nxt = 1'b1;
                    w_rcon_nxt     = 8'h01;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (r_rk_valid && io_kx.rk_ready) begin
                    if (r_rk_round == LAST_ROUND) begin
                        w_state_nxt    = ST_IDLE;
                        w_rk_valid_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else begin
`ifdef KEYEXP_SBOX_PIPE_EN
                        w_state_nxt    = ST_CALC;
                        w_rk_valid_nxt = 1'b0;
                        w_sub_nxt      = w_sub;
`else
                        // Without the pipe stage the next key is loaded on the handshake edge itself.
                        w_state_nxt    = ST_EMIT;
                        w_rk_out_nxt   = w_round_key;
                        w_rk_round_nxt = r_rk_round + 4'd1;
                        w_rcon_nxt     = w_rcon_xt;
`endif
                    end
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_CALC: begin
`ifdef KEYEXP_SBOX_PIPE_EN
                w_state_nxt    = ST_EMIT;
                w_rk_out_nxt   = w_round_key;
                w_rk_round_nxt = r_rk_round + 4'd1;
                w_rk_valid_nxt = 1'b1;
                w_rcon_nxt     = w_rcon_xt;
`else
                w_state_nxt    = ST_IDLE;
                w_rk_valid_nxt = 1'b0;
`endif
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_rk_valid_nxt = 1'b0;
            end
        endcase
        w_key_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_rk_out    <= 128'h0;
            r_rk_round  <= 4'd0;
            r_rcon      <= 8'h01;
        end else begin
            r_state     <= w_state_nxt;
            r_key_ready <= w_key_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rk_valid  <= w_rk_valid_nxt;
            r_rk_out    <= w_rk_out_nxt;
            r_rk_round  <= w_rk_round_nxt;
            r_rcon      <= w_rcon_nxt;
        end
    end

`ifdef KEYEXP_SBOX_PIPE_EN
    // SubWord pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 32'h0;
        end else begin
            r_sub <= w_sub_nxt;
        end
    end
`endif

    assign io_kx.key_ready = r_key_ready;
    assign io_kx.busy      = r_busy;
    assign io_kx.done      = r_done;
    assign io_kx.rk_valid  = r_rk_valid;
    assign io_kx.rk_out    = r_rk_out;
    assign io_kx.rk_round  = r_rk_round;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: expected round keys come from an independent
// key-schedule model whose S-box is derived from GF(2^8) inverses plus the affine map.
module tb_aes_key_expand;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;
    int   cyc;
    int   acc_cyc;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q[$];
    logic [7:0]   tb_sbox [256];
    logic [127:0] obs_rk [16];
    bit           stall_prev;
    logic [127:0] stall_out;
    logic [3:0]   stall_rnd;

`ifdef KEYEXP_SBOX_PIPE_EN
    localparam int EXP_LAT = 21;
`else
    localparam int EXP_LAT = 11;
`endif

    aes_key_expand_if kx ();

    aes_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_kx (kx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            tb_sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                         {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic push_expected(input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        exp_t        e;
        rc = 8'h01;
        {w0, w1, w2, w3} = key;
        e.rnd = 4'd0;
        e.key = key;
        sb_q.push_back(e);
        for (int r = 1; r <= 10; r++) begin
            t  = {tb_sbox[w3[23:16]], tb_sbox[w3[15:8]], tb_sbox[w3[7:0]], tb_sbox[w3[31:24]]}
                 ^ {rc, 24'h000000};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            e.rnd = 4'(r);
            e.key = {w0, w1, w2, w3};
            sb_q.push_back(e);
            rc = xt(rc);
        end
    endtask

    // One clock of scoreboard monitoring: sample at negedge, return at posedge+1.
    task automatic clk_cycle();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (stall_prev) begin
                checks++;
                if (kx.rk_valid !== 1'b1 || kx.rk_out !== stall_out || kx.rk_round !== stall_rnd) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %b round %0d key %h, expected valid 1 round %0d key %h",
                             kx.rk_valid, kx.rk_round, kx.rk_out, stall_rnd, stall_out);
                end
            end
            stall_prev = (kx.rk_valid === 1'b1) && (kx.rk_ready !== 1'b1);
            stall_out  = kx.rk_out;
            stall_rnd  = kx.rk_round;
            if (kx.done === 1'b1) done_cnt++;
            if (kx.rk_valid === 1'b1 && kx.rk_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got round %0d key %h, expected no round key", kx.rk_round, kx.rk_out);
                end else begin
                    e = sb_q.pop_front();
                    if (kx.rk_round !== e.rnd || kx.rk_out !== e.key) begin
                        errors++;
                        $display("FAIL sb_round_key: got round %0d key %h, expected round %0d key %h",
                                 kx.rk_round, kx.rk_out, e.rnd, e.key);
                    end
                end
                obs_rk[kx.rk_round] = kx.rk_out;
            end
            if (kx.key_valid === 1'b1 && kx.key_ready === 1'b1) begin
                push_expected(kx.key_in);
                acc_cyc = cyc + 1;
            end
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_done(input int budget, output bit timeout);
        int d0;
        d0 = done_cnt;
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            clk_cycle();
            if (done_cnt != d0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 16; i++) obs_rk[i] = 128'h0;
    endtask

    task automatic load_key(input logic [127:0] key);
        kx.key_in    = key;
        kx.key_valid = 1'b1;
        clk_cycle();
        kx.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (kx.key_ready !== 1'b1 || kx.rk_valid !== 1'b0 || kx.busy !== 1'b0 || kx.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready %b valid %b busy %b done %b, expected 1 0 0 0",
                     kx.key_ready, kx.rk_valid, kx.busy, kx.done);
        end
        checks++;
        if (kx.rk_out !== 128'h0 || kx.rk_round !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: got round %0d key %h, expected round 0 key 0", kx.rk_round, kx.rk_out);
        end
        rst_n = 1'b1;
        clk_cycle();
        checks++;
        if (kx.key_ready !== 1'b1 || kx.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready %b busy %b, expected 1 0", kx.key_ready, kx.busy);
        end
    endtask

    task automatic test_fips();
        bit to;
        int d0;
        clear_obs();
        kx.rk_ready = 1'b1;
        d0 = done_cnt;
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL fips_timeout: got no done, expected done within 100 cycles"); end
        checks++;
        if (obs_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL fips_round1: got %h, expected a0fafe1788542cb123a339392a6c7605", obs_rk[1]);
        end
        checks++;
        if (obs_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL fips_round10: got %h, expected d014f9a8c9ee2589e13f0cc8b6630ca6", obs_rk[10]);
        end
        clk_cycle();
        clk_cycle();
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++; $display("FAIL fips_done_pulses: got %0d, expected 1", done_cnt - d0);
        end
        checks++;
        if (sb_q.size() != 0 || kx.busy !== 1'b0) begin
            errors++; $display("FAIL fips_drain: got %0d pending busy %b, expected 0 pending busy 0", sb_q.size(), kx.busy);
        end
    endtask

    task automatic test_zero_key();
        bit to;
        clear_obs();
        load_key(128'h0);
        wait_done(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL zero_timeout: got no done, expected done within 100 cycles"); end
        checks++;
        if (obs_rk[1] !== 128'h62636363626363636263636362636363) begin
            errors++; $display("FAIL zero_round1: got %h, expected 62636363626363636263636362636363", obs_rk[1]);
        end
        checks++;
        if (obs_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++; $display("FAIL zero_round10: got %h, expected b4ef5bcb3e92e21123e951cf6f8f188e", obs_rk[10]);
        end
    endtask

    task automatic test_stalls();
        int d0;
        int stall_left;
        bit to;
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            stall_left = 0;
            to = 1'b1;
            load_key({$urandom, $urandom, $urandom, $urandom});
            for (int i = 0; i < 600; i++) begin
                if (stall_left > 0) begin
                    kx.rk_ready = 1'b0;
                    stall_left--;
                end else begin
                    kx.rk_ready = 1'b1;
                    stall_left = $urandom_range(0, 5);
                end
                clk_cycle();
                if (done_cnt != d0) begin
                    to = 1'b0;
                    break;
                end
            end
            checks++;
            if (to || sb_q.size() != 0) begin
                errors++; $display("FAIL stall_sequence: got timeout %b pending %0d, expected 0 0", to, sb_q.size());
            end
        end
        kx.rk_ready = 1'b1;
    endtask

    task automatic test_ignore_busy();
        bit to;
        int n;
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        n = 0;
        while (!(kx.rk_valid === 1'b1 && kx.rk_round === 4'd4) && n < 60) begin
            clk_cycle();
            n++;
        end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL busy_reach_round4: got round %0d, expected 4", kx.rk_round); end
        checks++;
        if (kx.key_ready !== 1'b0 || kx.busy !== 1'b1) begin
            errors++; $display("FAIL busy_key_ready: got ready %b busy %b, expected 0 1", kx.key_ready, kx.busy);
        end
        kx.key_in    = 128'hffeeddccbbaa99887766554433221100;
        kx.key_valid = 1'b1;
        clk_cycle();
        kx.key_valid = 1'b0;
        wait_done(100, to);
        clk_cycle();
        clk_cycle();
        checks++;
        if (to || sb_q.size() != 0 || kx.busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignore: got timeout %b pending %0d busy %b, expected 0 0 0", to, sb_q.size(), kx.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        load_key(128'h3243f6a8885a308d313198a2e0370734);
        n = 0;
        while (!(kx.rk_valid === 1'b1 && kx.rk_round === 4'd6) && n < 60) begin
            clk_cycle();
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (kx.key_ready !== 1'b1 || kx.rk_valid !== 1'b0 || kx.busy !== 1'b0 || kx.done !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got ready %b valid %b busy %b done %b, expected 1 0 0 0",
                               kx.key_ready, kx.rk_valid, kx.busy, kx.done);
        end
        checks++;
        if (kx.rk_out !== 128'h0 || kx.rk_round !== 4'd0) begin
            errors++; $display("FAIL async_reset_data: got round %0d key %h, expected round 0 key 0", kx.rk_round, kx.rk_out);
        end
        sb_q.delete();
        clk_cycle();
        clk_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_cycle();
            checks++;
            if (kx.rk_valid !== 1'b0 || kx.key_ready !== 1'b1) begin
                errors++; $display("FAIL post_reset_quiet: got valid %b ready %b, expected 0 1", kx.rk_valid, kx.key_ready);
            end
        end
        clear_obs();
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done(100, to);
        checks++;
        if (to || sb_q.size() != 0) begin
            errors++; $display("FAIL restart_sequence: got timeout %b pending %0d, expected 0 0", to, sb_q.size());
        end
        checks++;
        if (obs_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL restart_round1: got %h, expected a0fafe1788542cb123a339392a6c7605", obs_rk[1]);
        end
    endtask

    task automatic test_back_to_back();
        int a_acc;
        int r10_cyc;
        int done_cyc;
        bit to;
        r10_cyc  = -1;
        done_cyc = -1;
        kx.rk_ready  = 1'b1;
        kx.key_in    = 128'h00112233445566778899aabbccddeeff;
        kx.key_valid = 1'b1;
        clk_cycle();
        a_acc = acc_cyc;
        kx.key_in = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        for (int i = 0; i < 100; i++) begin
            clk_cycle();
            if (r10_cyc < 0 && kx.rk_valid === 1'b1 && kx.rk_round === 4'd10) r10_cyc = cyc;
            if (kx.done === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (kx.key_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready_in_done: got %b, expected 1", kx.key_ready);
                end
                clk_cycle();
                break;
            end
        end
        kx.key_valid = 1'b0;
        checks++;
        if (r10_cyc - a_acc + 1 != EXP_LAT) begin
            errors++; $display("FAIL b2b_latency: got %0d cycles, expected %0d", r10_cyc - a_acc + 1, EXP_LAT);
        end
        checks++;
        if (done_cyc < 0 || acc_cyc != done_cyc + 1) begin
            errors++; $display("FAIL b2b_accept_edge: got cycle %0d, expected %0d", acc_cyc, done_cyc + 1);
        end
        wait_done(100, to);
        checks++;
        if (to || sb_q.size() != 0) begin
            errors++; $display("FAIL b2b_second_key: got timeout %b pending %0d, expected 0 0", to, sb_q.size());
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        done_cnt     = 0;
        cyc          = 0;
        acc_cyc      = 0;
        stall_prev   = 1'b0;
        stall_out    = 128'h0;
        stall_rnd    = 4'd0;
        rst_n        = 1'b0;
        kx.key_in    = 128'h0;
        kx.key_valid = 1'b0;
        kx.rk_ready  = 1'b0;
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_stalls();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
